// File: rtl/vec_capture_fifo.sv
// vec_capture_fifo: capture stage for the 24-bit vector bus.
// Words strobed by the producer go into a small synchronous FIFO that a
// consumer drains through a valid/ready handshake. The block also keeps a
// running XOR checksum and a count of accepted words, so a whole vector set
// can be checked without comparing each word.
module vec_capture_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic [WIDTH-1:0] checksum,
  output logic [31:0]      total
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_nxt;
  logic             push;
  logic             pop;

  // A write into a full FIFO still lands when the head leaves in the same cycle.
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && (!full || pop);
  assign out_data  = mem[rd_ptr];

  // Occupancy after this edge; it also feeds the registered full/empty flags.
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end
  end

  // Storage array. It is never reset, and a clear discards the write.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers, occupancy, flags and checksum. A clear overrides any push or pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      checksum <= '0;
      total    <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
      checksum <= '0;
      total    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        checksum <= checksum ^ in_data;
        total    <= total + 32'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (in_valid && !push) begin
        overflow <= 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: tb/tb_vec_capture_fifo.sv
// Testbench for vec_capture_fifo. A queue-based reference model is checked
// against the DUT on every falling clock edge. Directed sequences pin the
// model with hand-computed literals, and a randomized phase follows them.
module tb_vec_capture_fifo;
  localparam int W = 24;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [4:0]   count;
  logic         full;
  logic         empty;
  logic         overflow;
  logic [W-1:0] checksum;
  logic [31:0]  total;

  int checks = 0;
  int failures = 0;

  vec_capture_fifo #(.WIDTH(W), .DEPTH(D), .AW(4)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .count(count),
    .full(full), .empty(empty), .overflow(overflow),
    .checksum(checksum), .total(total)
  );

  always #5 clk = ~clk;

  // reference model
  logic [W-1:0] mq[$];
  bit           m_ovf;
  logic [W-1:0] m_chk;
  logic [31:0]  m_tot;
  bit           m_pop, m_push;

  always @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      mq.delete();
      m_ovf = 1'b0;
      m_chk = '0;
      m_tot = '0;
    end else begin
      m_pop  = (mq.size() != 0) && out_ready;
      m_push = in_valid && ((mq.size() < D) || m_pop);
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back(in_data);
        m_chk = m_chk ^ in_data;
        m_tot = m_tot + 1;
      end else if (in_valid) begin
        m_ovf = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process
  always @(negedge clk) begin
    if (!rst) begin
      check("count", 32'(count), 32'(mq.size()));
      check("full", 32'(full), 32'(mq.size() == D));
      check("empty", 32'(empty), 32'(mq.size() == 0));
      check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("checksum", 32'(checksum), 32'(m_chk));
      check("total", total, m_tot);
      if (mq.size() != 0) check("out_data", 32'(out_data), 32'(mq[0]));
    end
  end

  task automatic step(input bit iv, input logic [W-1:0] d, input bit rdy, input bit clr);
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy;
    clear     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    check("rst_total", total, 32'd0);
  endtask

  // Entered at posedge+1. Reset pulses between edges and is released after the negedge.
  task automatic mid_reset(input bit do_check);
    #2 rst = 1'b1;
    #1;
    if (do_check) check_reset_vals();
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pin, pout;
    logic [W-1:0] rd;

    #1 rst = 1'b1;
    #2 check_reset_vals();
    @(posedge clk);
    #1 rst = 1'b0;

    // fill with 1..16
    for (int i = 1; i <= 16; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    check("fill_checksum", 32'(checksum), 32'h10);
    check("fill_total", total, 32'd16);
    check("fill_overflow", 32'(overflow), 32'd0);

    // dropped write when full
    step(1'b1, 24'hABCDEF, 1'b0, 1'b0);
    check("drop_overflow", 32'(overflow), 32'd1);
    check("drop_count", 32'(count), 32'd16);
    check("drop_total", total, 32'd16);
    check("drop_checksum", 32'(checksum), 32'h10);

    // drain in order
    for (int i = 0; i < 16; i++) begin
      check("drain_data", 32'(out_data), 32'(i + 1));
      step(1'b0, '0, 1'b1, 1'b0);
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_overflow", 32'(overflow), 32'd1);

    // full with simultaneous push and pop across pointer wrap
    step(1'b0, '0, 1'b0, 1'b1);
    check("clear_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) step(1'b1, W'(32'h100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, W'(32'h200 + i), 1'b1, 1'b0);
    check("pp_count", 32'(count), 32'd16);
    check("pp_overflow", 32'(overflow), 32'd0);
    check("pp_total", total, 32'd36);
    check("pp_head", 32'(out_data), 32'h204);

    // clear wins over a push in the same cycle
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 24'hFFFFFF, 1'b0, 1'b0);
    step(1'b1, 24'h0F0F0F, 1'b0, 1'b0);
    check("pre_clear_checksum", 32'(checksum), 32'hF0F0F0);
    step(1'b1, 24'h123456, 1'b0, 1'b1);
    check("clr_count", 32'(count), 32'd0);
    check("clr_checksum", 32'(checksum), 32'd0);
    check("clr_total", total, 32'd0);
    check("clr_overflow", 32'(overflow), 32'd0);
    check("clr_empty", 32'(empty), 32'd1);
    step(1'b1, 24'h654321, 1'b0, 1'b0);
    check("post_clr_data", 32'(out_data), 32'h654321);
    check("post_clr_checksum", 32'(checksum), 32'h654321);
    check("post_clr_total", total, 32'd1);

    // async reset mid-burst
    for (int i = 0; i < 5; i++) step(1'b1, W'(32'hA0 + i), 1'b1, 1'b0);
    in_valid = 1'b0;
    mid_reset(1'b1);
    step(1'b1, 24'hC0FFEE, 1'b0, 1'b0);
    check("post_rst_data", 32'(out_data), 32'hC0FFEE);
    check("post_rst_count", 32'(count), 32'd1);
    in_valid = 1'b0;

    // randomized traffic with biased push/pop rates
    pin = 70;
    pout = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        pin  = $urandom_range(20, 95);
        pout = $urandom_range(10, 95);
      end
      if ($urandom_range(0, 299) == 0) begin
        in_valid = 1'b0;
        mid_reset(1'b0);
      end else begin
        bit iv;
        iv = ($urandom_range(0, 99) < pin);
        rd = W'($urandom());
        if (!iv && $urandom_range(0, 3) == 0) rd = 'z;
        step(iv, rd, ($urandom_range(0, 99) < pout), ($urandom_range(0, 99) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
